// File: rtl/bram_load_sched.sv
// BRAM preload scheduler: streams PS words into score/subgraph/sum lanes,
// then hands the BRAMs to the engine. Optional LOAD_ZERO_FILL_EN zero-fills tails.
module bram_load_sched #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8192,
    parameter int PARALLEL   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   score_words,
    input  logic [ADDR_WIDTH:0]   graph_words,
    input  logic [ADDR_WIDTH:0]   sum_words,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic [ADDR_WIDTH-1:0] ld_addr,
    output logic [DATA_WIDTH-1:0] ld_data,
    output logic [PARALLEL-1:0]   score_we,
    output logic [PARALLEL-1:0]   graph_we,
    output logic [PARALLEL-1:0]   sum_we,
    output logic                  rdy_flag,
    input  logic                  engine_done,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int LW = (PARALLEL > 1) ? $clog2(PARALLEL) : 1;
    localparam logic [CW-1:0] DEPTH_S = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_M = CW'(DEPTH / 2);

`ifdef LOAD_ZERO_FILL_EN
    typedef enum logic [2:0] {IDLE, LOAD_S, LOAD_G, LOAD_M, RUN, FILL} state_e;
    typedef enum logic [1:0] {PH_S, PH_G, PH_M} ph_e;
`else
    typedef enum logic [2:0] {IDLE, LOAD_S, LOAD_G, LOAD_M, RUN} state_e;
`endif

    state_e                state_q, state_d, nxt_st;
    logic [LW-1:0]         lane_q, lane_d;
    logic [CW-1:0]         addr_q, addr_d;
    logic [CW-1:0]         s_cnt_q, s_cnt_d, g_cnt_q, g_cnt_d, m_cnt_q, m_cnt_d;
    logic [ADDR_WIDTH-1:0] ld_addr_q, ld_addr_d;
    logic [DATA_WIDTH-1:0] ld_data_q, ld_data_d;
    logic [PARALLEL-1:0]   score_we_q, score_we_d, graph_we_q, graph_we_d;
    logic [PARALLEL-1:0]   sum_we_q, sum_we_d;
    logic                  rdy_q, rdy_d, done_q, done_d, err_q, err_d;

    logic [CW-1:0]       cur_cnt;
    logic [PARALLEL-1:0] lane_oh;
    logic                accept, wrap, last, bad;

`ifdef LOAD_ZERO_FILL_EN
    ph_e           ph_q, ph_d, nxt_ph;
    logic [CW-1:0] fill_depth;

    // A zero-length phase goes straight to its fill.
    function automatic state_e enter(input logic [CW-1:0] c, input state_e ld);
        return (c == '0) ? FILL : ld;
    endfunction

    assign fill_depth = (ph_q == PH_M) ? DEPTH_M : DEPTH_S;

    always_comb begin
        nxt_st = RUN;
        nxt_ph = ph_q;
        unique case (ph_q)
            PH_S: begin
                nxt_st = enter(g_cnt_q, LOAD_G);
                nxt_ph = PH_G;
            end
            PH_G: begin
                nxt_st = enter(m_cnt_q, LOAD_M);
                nxt_ph = PH_M;
            end
            default: nxt_st = RUN;
        endcase
    end
`else
    // Skip phases whose latched count is zero.
    always_comb begin
        nxt_st = RUN;
        if (state_q == LOAD_S && g_cnt_q != '0)
            nxt_st = LOAD_G;
        else if (state_q != LOAD_M && m_cnt_q != '0)
            nxt_st = LOAD_M;
    end
`endif

    assign s_ready = (state_q == LOAD_S) || (state_q == LOAD_G) ||
                     (state_q == LOAD_M);
    assign busy    = (state_q != IDLE);
    assign accept  = s_valid & s_ready;
    assign lane_oh = PARALLEL'(1) << lane_q;
    assign wrap    = (lane_q == LW'(PARALLEL - 1));
    assign bad     = (score_words > DEPTH_S) || (graph_words > DEPTH_S) ||
                     (sum_words > DEPTH_M);

    always_comb begin
        cur_cnt = '0;
        unique case (state_q)
            LOAD_S:  cur_cnt = s_cnt_q;
            LOAD_G:  cur_cnt = g_cnt_q;
            LOAD_M:  cur_cnt = m_cnt_q;
            default: cur_cnt = '0;
        endcase
    end

    assign last = accept && wrap && (addr_q == cur_cnt - CW'(1));

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        addr_d     = addr_q;
        s_cnt_d    = s_cnt_q;
        g_cnt_d    = g_cnt_q;
        m_cnt_d    = m_cnt_q;
        ld_addr_d  = ld_addr_q;
        ld_data_d  = ld_data_q;
        score_we_d = '0;
        graph_we_d = '0;
        sum_we_d   = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        rdy_d      = (state_q == RUN) && !engine_done;
`ifdef LOAD_ZERO_FILL_EN
        ph_d       = ph_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (bad) begin
                        err_d = 1'b1;
                    end else begin
                        s_cnt_d = score_words;
                        g_cnt_d = graph_words;
                        m_cnt_d = sum_words;
                        lane_d  = '0;
                        addr_d  = '0;
`ifdef LOAD_ZERO_FILL_EN
                        ph_d    = PH_S;
                        state_d = enter(score_words, LOAD_S);
`else
                        if (score_words != '0)      state_d = LOAD_S;
                        else if (graph_words != '0) state_d = LOAD_G;
                        else if (sum_words != '0)   state_d = LOAD_M;
                        else                        state_d = RUN;
`endif
                    end
                end
            end
            LOAD_S, LOAD_G, LOAD_M: begin
                if (accept) begin
                    ld_addr_d  = addr_q[ADDR_WIDTH-1:0];
                    ld_data_d  = s_data;
                    score_we_d = (state_q == LOAD_S) ? lane_oh : '0;
                    graph_we_d = (state_q == LOAD_G) ? lane_oh : '0;
                    sum_we_d   = (state_q == LOAD_M) ? lane_oh : '0;
                    if (wrap) begin
                        lane_d = '0;
                        addr_d = addr_q + CW'(1);
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                    if (last) begin
                        lane_d = '0;
                        addr_d = '0;
`ifdef LOAD_ZERO_FILL_EN
                        if (cur_cnt == fill_depth) begin
                            state_d = nxt_st;
                            ph_d    = nxt_ph;
                        end else begin
                            state_d = FILL;
                            addr_d  = cur_cnt;
                        end
`else
                        state_d = nxt_st;
`endif
                    end
                end
            end
`ifdef LOAD_ZERO_FILL_EN
            FILL: begin
                ld_addr_d  = addr_q[ADDR_WIDTH-1:0];
                ld_data_d  = '0;
                score_we_d = (ph_q == PH_S) ? '1 : '0;
                graph_we_d = (ph_q == PH_G) ? '1 : '0;
                sum_we_d   = (ph_q == PH_M) ? '1 : '0;
                if (addr_q == fill_depth - CW'(1)) begin
                    state_d = nxt_st;
                    ph_d    = nxt_ph;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + CW'(1);
                end
            end
`endif
            RUN: begin
                if (engine_done) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            addr_q     <= '0;
            s_cnt_q    <= '0;
            g_cnt_q    <= '0;
            m_cnt_q    <= '0;
            ld_addr_q  <= '0;
            ld_data_q  <= '0;
            score_we_q <= '0;
            graph_we_q <= '0;
            sum_we_q   <= '0;
            rdy_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef LOAD_ZERO_FILL_EN
            ph_q       <= PH_S;
`endif
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            addr_q     <= addr_d;
            s_cnt_q    <= s_cnt_d;
            g_cnt_q    <= g_cnt_d;
            m_cnt_q    <= m_cnt_d;
            ld_addr_q  <= ld_addr_d;
            ld_data_q  <= ld_data_d;
            score_we_q <= score_we_d;
            graph_we_q <= graph_we_d;
            sum_we_q   <= sum_we_d;
            rdy_q      <= rdy_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef LOAD_ZERO_FILL_EN
            ph_q       <= ph_d;
`endif
        end
    end

    assign ld_addr  = ld_addr_q;
    assign ld_data  = ld_data_q;
    assign score_we = score_we_q;
    assign graph_we = graph_we_q;
    assign sum_we   = sum_we_q;
    assign rdy_flag = rdy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: doc/bram_load_sched.md
Name: bram_load_sched

Overview:
- Hardware replacement for the PS-side BRAM preload currently done in simulation.
- Accepts a word stream from the PS and writes it into the PARALLEL lanes of bram_score_table, bram_subgraph and bram_score_sum_table.
- Raises rdy_flag to release top_quad_generate and gate its clock.
- Waits for the engine's completion pulse, then returns BRAM ownership to the PS.

Parameters:
- ADDR_WIDTH, 13: BRAM address width.
- DATA_WIDTH, 32: word width.
- DEPTH, 8192: score/subgraph table depth; sum table depth is DEPTH/2.
- PARALLEL, 4: number of BRAM lanes per table.

Ports:
- clk  in  1  single clock, shared with all BRAMs.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches the word counts and begins loading.
- score_words  in  ADDR_WIDTH+1  addresses per lane to load into the score tables.
- graph_words  in  ADDR_WIDTH+1  addresses per lane to load into the subgraph tables.
- sum_words  in  ADDR_WIDTH+1  addresses per lane to load into the sum tables.
- s_valid  in  1  PS stream word valid.
- s_ready  out  1  block accepts a stream word.
- s_data  in  DATA_WIDTH  PS stream word.
- ld_addr  out  ADDR_WIDTH  BRAM write address, common to all lanes.
- ld_data  out  DATA_WIDTH  BRAM write data.
- score_we  out  PARALLEL  per-lane write enable, score tables.
- graph_we  out  PARALLEL  per-lane write enable, subgraph tables.
- sum_we  out  PARALLEL  per-lane write enable, sum tables.
- rdy_flag  out  1  1 = engine owns BRAMs and clock; 0 = PS/loader owns them.
- engine_done  in  1  one-cycle pulse from the diffusion engine.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on the RUN->IDLE transition.
- err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE; counters cleared. Reset mid-operation abandons the load immediately; BRAM contents are undefined afterwards.
- States: IDLE, LOAD_S, LOAD_G, LOAD_M, RUN.
- IDLE, start=1, any out-of-range count: err pulses, FSM stays in IDLE.
  - score_words>DEPTH, graph_words>DEPTH or sum_words>DEPTH/2 is out of range.
- IDLE, start=1, all counts in range: counts are latched and FSM goes to the first phase with a nonzero count, in order S, G, M. If all counts are 0, FSM goes straight to RUN.
- start while busy: ignored.
- s_ready=1 only in LOAD_* states; a beat is accepted when s_valid & s_ready.
- Beat order within a phase: lane 0..PARALLEL-1 at address 0, then lane 0..PARALLEL-1 at address 1, and so on.
  - The lane counter wraps to 0 after lane PARALLEL-1, then the address increments.
- Write latency: an accepted beat drives ld_addr/ld_data and exactly one bit of the phase's we vector on the following cycle, for one cycle. We outputs are 0 in all other cycles.
- Phase end: when the beat at address count-1, lane PARALLEL-1 is accepted, counters clear and FSM moves to the next nonzero phase, or to RUN.
  - s_ready drops in the cycle after the final beat. No beat is lost or duplicated across the phase boundary.
- RUN: rdy_flag=1, registered, asserted the cycle after entering RUN, and held until engine_done.
- engine_done in RUN: rdy_flag=0 and done=1 the next cycle, FSM goes to IDLE.
- engine_done outside RUN: ignored.
- s_valid outside LOAD_*: ignored; s_ready stays 0.

Optional Feature:
- Macro: LOAD_ZERO_FILL_EN
- With the macro: after the last streamed beat of each phase, a fill sub-state writes zero to every address from count to table depth-1 (DEPTH, or DEPTH/2 for M).
  - All PARALLEL bits of that phase's we vector are asserted together, one address per cycle.
  - s_ready=0 during the fill; the next phase starts after the fill completes.
  - Phases with count 0 are fully zero-filled, not skipped.
- Without the macro: no fill; addresses beyond count are untouched.

Test Plan:
- Basic load: score_words=2, graph_words=1, sum_words=1, s_valid always high, data 1,2,3...
  - score_we pattern 0001,0010,0100,1000 at addr 0, then the same at addr 1.
  - graph_we at addr 0 carries data 9..12; sum_we at addr 0 carries data 13..16.
  - rdy_flag=1 two cycles after the last beat.
- Backpressure: s_valid toggled 1/0 every cycle with counts 1,0,0.
  - Exactly 4 score writes, data in order, no gaps or duplicates; G and M phases skipped.
- Range check: score_words=8193 -> err pulse, busy stays 0, no we activity.
- Completion: in RUN, pulse engine_done -> rdy_flag=0 and done=1 next cycle, busy=0. A second engine_done in IDLE has no effect.
- Mid-load reset: assert rst_n=0 after 5 accepted beats -> all outputs 0 asynchronously; a fresh start reloads from addr 0, lane 0.
- With LOAD_ZERO_FILL_EN and sum_words=4094: after the streamed beats, sum_we=1111 with ld_data=0 at addr 4094 and 4095, then RUN.
